// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline payload types and default widths
package pipe_pkg;

    localparam int PIPE_ADDR_W = 5;
    localparam int PIPE_DATA_W = 32;

    // MEM->WB payload; field widths follow the package defaults above
    typedef struct packed {
        logic [PIPE_ADDR_W-1:0] rd_addr;
        logic [PIPE_DATA_W-1:0] rd_data;
        logic                   rd_wen;
        logic                   mem_re;
        logic [PIPE_DATA_W-1:0] ram_data;
    } mem_wb_pkt_t;

endpackage

// File: rtl/mem_wb_slot.sv
// rtl/mem_wb_slot.sv - one payload register plus valid bit with load/clear
module mem_wb_slot
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  mem_wb_pkt_t d,
    output logic        valid,
    output mem_wb_pkt_t q
);

    // Clear wins over load; clearing also zeroes the payload so an empty
    // slot never carries a stale write enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// rtl/mem_wb_skid.sv - MEM/WB 2-entry skid buffer; optional forwarding via MEM_WB_SKID_FWD_EN
module mem_wb_skid
    import pipe_pkg::*;
#(
    parameter int ADDR_W = PIPE_ADDR_W,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              rd_wen_i,
    input  logic              mem_re_i,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_wen_o,
    output logic              mem_re_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic [DATA_W-1:0] wb_data_o,
`ifdef MEM_WB_SKID_FWD_EN
    output logic              fwd_valid_o,
    output logic [ADDR_W-1:0] fwd_addr_o,
    output logic [DATA_W-1:0] fwd_data_o,
`endif
    output logic              wb_wen_o
);

    mem_wb_pkt_t pkt_in;
    mem_wb_pkt_t main_q;
    mem_wb_pkt_t skid_q;
    mem_wb_pkt_t main_d;
    logic        main_valid;
    logic        skid_valid;
    logic        main_load;
    logic        main_clear;
    logic        main_sel_skid;
    logic        skid_load;
    logic        skid_clear;
    logic        in_ready_q;
    logic        accept;
    logic        retire;

    assign pkt_in = '{rd_addr:  rd_addr_i,
                      rd_data:  rd_data_i,
                      rd_wen:   rd_wen_i,
                      mem_re:   mem_re_i,
                      ram_data: ram_data_i};

    assign accept = in_valid_i && in_ready_q;
    assign retire = main_valid && out_ready_i;
    assign main_d = main_sel_skid ? skid_q : pkt_in;

    // Slot control: flush beats everything, a retiring main slot refills from
    // skid first, otherwise an accept lands in main if free or in skid.
    always_comb begin
        main_load     = 1'b0;
        main_clear    = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        if (flush_i) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (retire) begin
            if (skid_valid) begin
                main_load     = 1'b1;
                main_sel_skid = 1'b1;
                skid_clear    = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_load = 1'b1;
            end else begin
                main_load = 1'b1;
            end
        end
    end

    mem_wb_slot u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    mem_wb_slot u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (pkt_in),
        .valid (skid_valid),
        .q     (skid_q)
    );

    // Registered ready mirrors the next skid occupancy, so out_ready_i never
    // reaches in_ready_o combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q <= 1'b1;
        end else if (skid_clear) begin
            in_ready_q <= 1'b1;
        end else if (skid_load) begin
            in_ready_q <= 1'b0;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid;
    assign rd_addr_o   = main_q.rd_addr;
    assign rd_data_o   = main_q.rd_data;
    assign rd_wen_o    = main_valid && main_q.rd_wen;
    assign mem_re_o    = main_q.mem_re;
    assign ram_data_o  = main_q.ram_data;
    assign wb_data_o   = main_q.mem_re ? main_q.ram_data : main_q.rd_data;
    assign wb_wen_o    = out_valid_o && out_ready_i && rd_wen_o && (rd_addr_o != '0);

`ifdef MEM_WB_SKID_FWD_EN
    assign fwd_valid_o = out_valid_o && rd_wen_o && (rd_addr_o != '0);
    assign fwd_addr_o  = rd_addr_o;
    assign fwd_data_o  = wb_data_o;
`endif

endmodule

// File: tb/tb_mem_wb_skid.sv
// tb/tb_mem_wb_skid.sv - scoreboard bench for mem_wb_skid
module tb_mem_wb_skid;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rd_wen_i;
    logic        mem_re_i;
    logic [31:0] ram_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;
    logic        mem_re_o;
    logic [31:0] ram_data_o;
    logic [31:0] wb_data_o;
    logic        wb_wen_o;
`ifdef MEM_WB_SKID_FWD_EN
    logic        fwd_valid_o;
    logic [4:0]  fwd_addr_o;
    logic [31:0] fwd_data_o;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wb_data;
        logic        wen;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mem_wb_skid dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .rd_addr_i   (rd_addr_i),
        .rd_data_i   (rd_data_i),
        .rd_wen_i    (rd_wen_i),
        .mem_re_i    (mem_re_i),
        .ram_data_i  (ram_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .rd_addr_o   (rd_addr_o),
        .rd_data_o   (rd_data_o),
        .rd_wen_o    (rd_wen_o),
        .mem_re_o    (mem_re_o),
        .ram_data_o  (ram_data_o),
        .wb_data_o   (wb_data_o),
`ifdef MEM_WB_SKID_FWD_EN
        .fwd_valid_o (fwd_valid_o),
        .fwd_addr_o  (fwd_addr_o),
        .fwd_data_o  (fwd_data_o),
`endif
        .wb_wen_o    (wb_wen_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every WB handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_wb: addr=0x%0h data=0x%0h wen=%0b with no entry outstanding",
                         rd_addr_o, wb_data_o, wb_wen_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_addr", 32'(rd_addr_o), 32'(e.addr));
                chk("wb_data", wb_data_o, e.wb_data);
                chk("wb_wen", 32'(wb_wen_o), 32'(e.wen));
`ifdef MEM_WB_SKID_FWD_EN
                chk("fwd_valid", 32'(fwd_valid_o), 32'(e.wen));
                chk("fwd_data", fwd_data_o, e.wb_data);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] a, input logic [31:0] d, input logic wen, input logic re,
                        input logic [31:0] ram, input logic [31:0] exp_wb, input logic exp_wen);
        exp_t e;
        in_valid_i = 1'b1;
        rd_addr_i  = a;
        rd_data_i  = d;
        rd_wen_i   = wen;
        mem_re_i   = re;
        ram_data_i = ram;
        if (in_ready_o && !flush_i) begin
            e.addr    = a;
            e.wb_data = exp_wb;
            e.wen     = exp_wen;
            exp_q.push_back(e);
        end
        step();
        in_valid_i = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        rd_addr_i  = '0;
        rd_data_i  = '0;
        rd_wen_i   = 1'b0;
        mem_re_i   = 1'b0;
        ram_data_i = '0;
        out_ready_i = 1'b0;

        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_rd_wen", 32'(rd_wen_o), 32'd0);
        chk("rst_wb_wen", 32'(wb_wen_o), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        step();

        // Basic pass-through, latency one
        out_ready_i = 1'b1;
        send(5'd5, 32'h1234, 1'b1, 1'b0, 32'h0, 32'h1234, 1'b1);
        chk("lat1_out_valid", 32'(out_valid_o), 32'd1);
        chk("lat1_wb_wen", 32'(wb_wen_o), 32'd1);
        step();
        chk("idle_out_valid", 32'(out_valid_o), 32'd0);

        // Load data selected over ALU result
        send(5'd7, 32'h10, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        // x0 destination never writes back
        send(5'd0, 32'h55, 1'b1, 1'b0, 32'h0, 32'h55, 1'b0);
        chk("x0_wb_wen", 32'(wb_wen_o), 32'd0);
        // rd_wen=0 entry
        send(5'd3, 32'h77, 1'b0, 1'b0, 32'h0, 32'h77, 1'b0);

        // Back-to-back streaming keeps ready high
        send(5'd1, 32'h101, 1'b1, 1'b0, 32'h0, 32'h101, 1'b1);
        send(5'd2, 32'h202, 1'b1, 1'b1, 32'h2020, 32'h2020, 1'b1);
        send(5'd4, 32'h404, 1'b1, 1'b0, 32'h0, 32'h404, 1'b1);
        chk("stream_in_ready", 32'(in_ready_o), 32'd1);
        step();

        // Backpressure: A then B, skid fills, order preserved
        out_ready_i = 1'b0;
        send(5'd10, 32'hA, 1'b1, 1'b0, 32'h0, 32'hA, 1'b1);
        chk("bp_in_ready_after_a", 32'(in_ready_o), 32'd1);
        send(5'd11, 32'hB, 1'b1, 1'b0, 32'h0, 32'hB, 1'b1);
        chk("bp_in_ready_after_b", 32'(in_ready_o), 32'd0);
        chk("bp_hold_a", rd_data_o, 32'hA);
        step();
        chk("bp_hold_a_again", rd_data_o, 32'hA);
        chk("bp_no_wb_wen", 32'(wb_wen_o), 32'd0);
        out_ready_i = 1'b1;
        step();
        chk("bp_b_in_main", rd_data_o, 32'hB);
        chk("bp_in_ready_back", 32'(in_ready_o), 32'd1);
        step();
        chk("bp_drained", 32'(out_valid_o), 32'd0);

        // Flush with both slots full and an input offered
        out_ready_i = 1'b0;
        send(5'd12, 32'hC1, 1'b1, 1'b0, 32'h0, 32'hC1, 1'b1);
        send(5'd13, 32'hC2, 1'b1, 1'b0, 32'h0, 32'hC2, 1'b1);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        rd_addr_i  = 5'd14;
        rd_data_i  = 32'hC3;
        rd_wen_i   = 1'b1;
        mem_re_i   = 1'b0;
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", 32'(out_valid_o), 32'd0);
        chk("flush_in_ready", 32'(in_ready_o), 32'd1);
        chk("flush_rd_wen", 32'(rd_wen_o), 32'd0);
        out_ready_i = 1'b1;
        repeat (3) step();

        // Asynchronous reset mid-stream with skid full
        out_ready_i = 1'b0;
        send(5'd20, 32'hE1, 1'b1, 1'b0, 32'h0, 32'hE1, 1'b1);
        send(5'd21, 32'hE2, 1'b1, 1'b0, 32'h0, 32'hE2, 1'b1);
        chk("pre_rst_in_ready", 32'(in_ready_o), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid_o), 32'd0);
        chk("arst_in_ready", 32'(in_ready_o), 32'd1);
        chk("arst_wb_data", wb_data_o, 32'd0);
        chk("arst_rd_addr", 32'(rd_addr_o), 32'd0);
        chk("arst_rd_wen", 32'(rd_wen_o), 32'd0);
        exp_q.delete();
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        repeat (3) step();
        chk("post_rst_out_valid", 32'(out_valid_o), 32'd0);

        // Normal operation resumes
        send(5'd9, 32'h99, 1'b1, 1'b0, 32'h0, 32'h99, 1'b1);
        step();
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
